// File: rtl/rx_frame_parser_if.sv
// Purpose: byte-wide receive AXI-Stream bundle from the MAC into the frame parser.
// Handshake: a byte moves on a rising clock edge where tvalid and tready are both
//   high; tlast marks the final byte of a frame and tuser (bad frame) is only
//   meaningful together with tlast.
// Signals:
//   tdata  [7:0]  receive byte
//   tvalid        byte valid
//   tlast         last byte of frame
//   tuser         MAC bad-frame flag
//   tready        sink can accept a byte
// Modports: master = MAC side (drives data), slave = parser side (drives tready).
interface rx_frame_parser_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
    logic       tready;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/rx_frame_parser.sv
// Purpose: receive-side frame parser. Captures the 14-byte Ethernet header into
//   registers, streams payload bytes into the shared payload buffer and, after a
//   good-length frame ends, presents header fields plus payload length with
//   rx_header_valid until the transmit controller pulses hdr_ack.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_axis           byte stream from the MAC (slave side)
//   brx_full          payload buffer full
//   brx_wr_en/_data   registered payload write strobe and byte
//   hdr_ack           controller took the header (1-cycle pulse)
//   rx_header_valid   header/length registers valid
//   hdr_dst_mac/hdr_src_mac/hdr_type  captured header, first byte in the MSBs
//   payload_len       payload bytes written for this frame (saturates at SIZE)
//   frame_err         bad-frame flag or truncated payload
//   frame_cnt/drop_cnt delivered / dropped frame counters (wrap)
//   dbg_state         current FSM state
// Build option: define RX_ADDR_FILTER_EN to drop frames whose destination is
//   neither LOCAL_MAC nor broadcast (decided when byte 5 arrives).
module rx_frame_parser #(
    parameter int unsigned SIZE      = 2048,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_frame_parser_if.slave     rx_axis,
    input  logic                 brx_full,
    output logic                 brx_wr_en,
    output logic [7:0]           brx_wr_data,
    input  logic                 hdr_ack,
    output logic                 rx_header_valid,
    output logic [47:0]          hdr_dst_mac,
    output logic [47:0]          hdr_src_mac,
    output logic [15:0]          hdr_type,
    output logic [15:0]          payload_len,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          drop_cnt,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HEADER   = 3'd1,
        PAYLOAD  = 3'd2,
        WAIT_ACK = 3'd3,
        DROP     = 3'd4
    } state_t;

`ifdef RX_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    state_t      state;
    logic [3:0]  hdr_idx;

    logic        accept;
    logic [47:0] next_dst;
    logic        addr_match;
    logic        store;
    logic        err_next;

    // tready is combinational on rst so it is low for exactly the reset cycles.
    assign rx_axis.tready = !rst && (state != WAIT_ACK);
    assign accept         = rx_axis.tvalid && rx_axis.tready;

    // Destination as it will look once the current byte is shifted in.
    assign next_dst   = {hdr_dst_mac[39:0], rx_axis.tdata};
    assign addr_match = (next_dst == LOCAL_MAC) || (next_dst == 48'hFFFF_FFFF_FFFF);

    // A payload byte is written only if the buffer has room and the frame
    // has not yet reached SIZE bytes; otherwise it is discarded and flagged.
    assign store    = !brx_full && (payload_len < 16'(SIZE));
    assign err_next = frame_err || !store || (rx_axis.tlast && rx_axis.tuser);

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            hdr_idx         <= 4'd0;
            brx_wr_en       <= 1'b0;
            brx_wr_data     <= 8'd0;
            rx_header_valid <= 1'b0;
            hdr_dst_mac     <= 48'd0;
            hdr_src_mac     <= 48'd0;
            hdr_type        <= 16'd0;
            payload_len     <= 16'd0;
            frame_err       <= 1'b0;
            frame_cnt       <= 16'd0;
            drop_cnt        <= 16'd0;
        end else begin
            brx_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        hdr_dst_mac <= next_dst;
                        hdr_idx     <= 4'd1;
                        if (rx_axis.tlast) begin
                            drop_cnt <= drop_cnt + 16'd1;
                        end else begin
                            state <= HEADER;
                        end
                    end
                end

                HEADER: begin
                    if (accept) begin
                        // Shift registers: after all bytes of a field arrive the
                        // first byte has reached the MSBs.
                        if (hdr_idx < 4'd6) begin
                            hdr_dst_mac <= next_dst;
                        end else if (hdr_idx < 4'd12) begin
                            hdr_src_mac <= {hdr_src_mac[39:0], rx_axis.tdata};
                        end else begin
                            hdr_type <= {hdr_type[7:0], rx_axis.tdata};
                        end
                        hdr_idx <= hdr_idx + 4'd1;

                        if (hdr_idx == 4'd13) begin
                            payload_len <= 16'd0;
                            frame_err   <= rx_axis.tlast && rx_axis.tuser;
                            if (rx_axis.tlast) begin
                                rx_header_valid <= 1'b1;
                                state           <= WAIT_ACK;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end else if (rx_axis.tlast) begin
                            drop_cnt <= drop_cnt + 16'd1;
                            state    <= IDLE;
                        end else if (FILTER_EN && (hdr_idx == 4'd5) && !addr_match) begin
                            state <= DROP;
                        end
                    end
                end

                PAYLOAD: begin
                    if (accept) begin
                        if (store) begin
                            brx_wr_en   <= 1'b1;
                            brx_wr_data <= rx_axis.tdata;
                            payload_len <= payload_len + 16'd1;
                        end
                        frame_err <= err_next;
                        if (rx_axis.tlast) begin
                            rx_header_valid <= 1'b1;
                            state           <= WAIT_ACK;
                        end
                    end
                end

                WAIT_ACK: begin
                    if (hdr_ack) begin
                        rx_header_valid <= 1'b0;
                        frame_cnt       <= frame_cnt + 16'd1;
                        state           <= IDLE;
                    end
                end

                DROP: begin
                    if (accept && rx_axis.tlast) begin
                        drop_cnt <= drop_cnt + 16'd1;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
